pm_snapshot_streamer: RTL and testbench

PM_SNAPSHOT_STREAMER -- requirements
Module: pm_snapshot_streamer

---
 rtl/pm_snapshot_streamer.sv | 106 ++++++++++
 tb/tb_pm_snapshot_streamer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_snapshot_streamer.sv
// Captures per-inport SA counters on request and streams them as one
// valid/ready frame: a header word, then the four 32-bit halves of each port.
module pm_snapshot_streamer #(
  parameter int INPUT_PORT_NUM = 5,
  parameter int CNT_W          = 64,
  parameter int WORD_NUM       = 1 + 4 * INPUT_PORT_NUM,
  parameter int NODE_ID_X_W    = 8,
  parameter int NODE_ID_Y_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 snap_req_i,
  input  logic [INPUT_PORT_NUM-1:0][CNT_W-1:0] sa_local_cnt_i,
  input  logic [INPUT_PORT_NUM-1:0][CNT_W-1:0] sa_global_cnt_i,
  input  logic [NODE_ID_X_W-1:0]               node_id_x_ths_hop_i,
  input  logic [NODE_ID_Y_W-1:0]               node_id_y_ths_hop_i,
  output logic                                 out_vld_o,
  input  logic                                 out_rdy_i,
  output logic [31:0]                          out_data_o,
  output logic                                 out_last_o,
  output logic                                 busy_o,
  output logic [7:0]                           snap_drop_cnt_o
);

  localparam int IDX_W = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
  localparam int TBL_N = 1 << IDX_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                 state;
  logic [IDX_W-1:0]                       idx;
  logic [INPUT_PORT_NUM-1:0][CNT_W-1:0]   snap_local;
  logic [INPUT_PORT_NUM-1:0][CNT_W-1:0]   snap_global;

  logic [31:0]      word_tbl [TBL_N];
  logic [31:0]      header_word;
  logic [IDX_W-1:0] idx_nxt;
  logic             handshake;
  logic             frame_done;
  logic             start_frame;

  // The header is built from the live node ID; it is latched into out_data_o
  // on the capture edge, which is what freezes the ID for the whole frame.
  assign header_word = {8'hA5, 8'(INPUT_PORT_NUM),
                        8'(node_id_x_ths_hop_i), 8'(node_id_y_ths_hop_i)};

  assign handshake   = out_vld_o & out_rdy_i;
  assign frame_done  = handshake & out_last_o;
  assign start_frame = snap_req_i & ((state == IDLE) | frame_done);
  assign idx_nxt     = idx + IDX_W'(1);
  assign busy_o      = (state == SEND);

  // Payload words from the snapshot; entry 0 (header) is never looked up here.
  always_comb begin
    for (int i = 0; i < TBL_N; i++) word_tbl[i] = '0;
    for (int p = 0; p < INPUT_PORT_NUM; p++) begin
      word_tbl[1 + 4*p] = snap_local[p][31:0];
      word_tbl[2 + 4*p] = snap_local[p][63:32];
      word_tbl[3 + 4*p] = snap_global[p][31:0];
      word_tbl[4 + 4*p] = snap_global[p][63:32];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      idx             <= '0;
      // NOTE: the snapshot bank is deliberately reset so no stale counter
      // value can ever reach the stream after a reset.
      snap_local      <= '0;
      snap_global     <= '0;
      snap_drop_cnt_o <= '0;
      out_vld_o       <= 1'b0;
      out_last_o      <= 1'b0;
      out_data_o      <= '0;
    end else begin
      if (start_frame) begin
        state       <= SEND;
        idx         <= '0;
        snap_local  <= sa_local_cnt_i;
        snap_global <= sa_global_cnt_i;
        out_vld_o   <= 1'b1;
        out_data_o  <= header_word;
        out_last_o  <= (WORD_NUM == 1);
      end else if (frame_done) begin
        state      <= IDLE;
        idx        <= '0;
        out_vld_o  <= 1'b0;
        out_data_o <= '0;
        out_last_o <= 1'b0;
      end else if (handshake) begin
        idx        <= idx_nxt;
        out_data_o <= word_tbl[idx_nxt];
        out_last_o <= (idx_nxt == IDX_W'(WORD_NUM - 1));
      end

      // A request while a frame is in flight is lost unless it lands exactly
      // on the final handshake, where it chains the next frame instead.
      if (snap_req_i && (state == SEND) && !frame_done && (snap_drop_cnt_o != 8'hFF))
        snap_drop_cnt_o <= snap_drop_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_pm_snapshot_streamer.sv
// Directed bench for pm_snapshot_streamer: basic frame, backpressure, drop
// counter saturation, back-to-back frames and reset in the middle of a frame.
module tb_pm_snapshot_streamer;

  localparam int N        = 5;
  localparam int WORD_NUM = 1 + 4 * N;

  logic              clk = 1'b0;
  logic              rstn;
  logic              snap_req;
  logic [N-1:0][63:0] sa_local;
  logic [N-1:0][63:0] sa_global;
  logic [7:0]        node_x;
  logic [7:0]        node_y;
  logic              out_vld;
  logic              out_rdy;
  logic [31:0]       out_data;
  logic              out_last;
  logic              busy;
  logic [7:0]        drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] exp_local  [N];
  logic [63:0] exp_global [N];
  logic [7:0]  exp_x;
  logic [7:0]  exp_y;

  pm_snapshot_streamer #(.INPUT_PORT_NUM(N)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .snap_req_i          (snap_req),
    .sa_local_cnt_i      (sa_local),
    .sa_global_cnt_i     (sa_global),
    .node_id_x_ths_hop_i (node_x),
    .node_id_y_ths_hop_i (node_y),
    .out_vld_o           (out_vld),
    .out_rdy_i           (out_rdy),
    .out_data_o          (out_data),
    .out_last_o          (out_last),
    .busy_o              (busy),
    .snap_drop_cnt_o     (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int k);
    int p;
    if (k == 0) return {8'hA5, 8'd5, exp_x, exp_y};
    p = (k - 1) / 4;
    case ((k - 1) % 4)
      0:       return exp_local[p][31:0];
      1:       return exp_local[p][63:32];
      2:       return exp_global[p][31:0];
      default: return exp_global[p][63:32];
    endcase
  endfunction

  task automatic set_pattern1();
    for (int p = 0; p < N; p++) begin
      sa_local[p]  = 64'h1_0000_0000 + 64'(p);
      sa_global[p] = 64'(p);
    end
    node_x = 8'd2;
    node_y = 8'd3;
  endtask

  task automatic set_pattern2();
    for (int p = 0; p < N; p++) begin
      sa_local[p]  = 64'hCAFE_0000_F00D_0000 + 64'(p) * 64'h0000_0001_0000_0011;
      sa_global[p] = 64'h8000_0000_7FFF_FFFF - 64'(p);
    end
    node_x = 8'h0F;
    node_y = 8'h1E;
  endtask

  task automatic capture_exp();
    for (int p = 0; p < N; p++) begin
      exp_local[p]  = sa_local[p];
      exp_global[p] = sa_global[p];
    end
    exp_x = node_x;
    exp_y = node_y;
  endtask

  // Entered at the negedge where the header should be visible; leaves at the
  // negedge after the last handshake (or one reset edge after abort_at).
  task automatic run_frame(input int stall_at, input int stall_len,
                           input bit pulse_drops, input bit chain, input int abort_at);
    int k;
    int st;
    k  = 0;
    st = 0;
    while (k < WORD_NUM) begin
      vectors++;
      if (out_vld !== 1'b1 || out_data !== exp_word(k) ||
          out_last !== (k == WORD_NUM - 1) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL frame_word%0d: got vld=%b data=%h last=%b busy=%b, want vld=1 data=%h last=%b busy=1",
                 k, out_vld, out_data, out_last, busy, exp_word(k), (k == WORD_NUM - 1));
      end
      if (k == abort_at) begin
        rstn     = 1'b0;
        snap_req = 1'b0;
        @(negedge clk);
        return;
      end
      if (k == stall_at && st < stall_len) begin
        out_rdy  = 1'b0;
        snap_req = pulse_drops && (st % 2 == 0);
        sa_local[st % N]  = 64'hDEAD_BEEF_0000_0000 | 64'(st);
        sa_global[st % N] = ~sa_global[st % N];
        node_x = node_x + 8'd1;
        st++;
      end else begin
        out_rdy  = 1'b1;
        snap_req = chain && (k == WORD_NUM - 1);
        k++;
      end
      @(negedge clk);
    end
    snap_req = 1'b0;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    snap_req = 1'b0;
    out_rdy  = 1'b1;
    set_pattern1();
    repeat (3) @(negedge clk);
    vectors++;
    if (out_vld !== 1'b0 || out_data !== 32'h0 || out_last !== 1'b0 ||
        busy !== 1'b0 || drop_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_state: got vld=%b data=%h last=%b busy=%b drop=%0d, want all zero",
               out_vld, out_data, out_last, busy, drop_cnt);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_req: got vld=%b busy=%b, want 0 0", out_vld, busy);
    end
  endtask

  task automatic test_basic_frame();
    set_pattern1();
    capture_exp();
    snap_req = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_data !== 32'hA505_0203 || out_vld !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_header: got vld=%b data=%h, want vld=1 data=a5050203", out_vld, out_data);
    end
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || drop_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL basic_end: got vld=%b busy=%b data=%h drop=%0d, want 0 0 0 0",
               out_vld, busy, out_data, drop_cnt);
    end
  endtask

  task automatic test_backpressure();
    set_pattern2();
    capture_exp();
    snap_req = 1'b1;
    @(negedge clk);
    run_frame(7, 5, 1'b0, 1'b0, -1);
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_end: got vld=%b busy=%b, want 0 0", out_vld, busy);
    end
  endtask

  task automatic test_drop_counter();
    set_pattern1();
    node_x = 8'd1;
    node_y = 8'd0;
    capture_exp();
    snap_req = 1'b1;
    @(negedge clk);
    run_frame(3, 600, 1'b1, 1'b0, -1);
    vectors++;
    if (drop_cnt !== 8'd255 || out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_saturate: got drop=%0d vld=%b, want drop=255 vld=0", drop_cnt, out_vld);
    end
  endtask

  task automatic test_back_to_back();
    set_pattern1();
    capture_exp();
    snap_req = 1'b1;
    @(negedge clk);
    set_pattern2();
    run_frame(-1, 0, 1'b0, 1'b1, -1);
    capture_exp();
    vectors++;
    if (out_vld !== 1'b1 || busy !== 1'b1 || out_data !== 32'hA505_0F1E) begin
      miscompares++;
      $display("FAIL b2b_header: got vld=%b busy=%b data=%h, want 1 1 a5050f1e", out_vld, busy, out_data);
    end
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got vld=%b busy=%b, want 0 0", out_vld, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    set_pattern2();
    capture_exp();
    snap_req = 1'b1;
    @(negedge clk);
    run_frame(-1, 0, 1'b0, 1'b0, 10);
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 ||
        out_last !== 1'b0 || drop_cnt !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid: got vld=%b busy=%b data=%h last=%b drop=%0d, want all zero",
               out_vld, busy, out_data, out_last, drop_cnt);
    end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_vld !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet%0d: got vld=%b busy=%b, want 0 0", i, out_vld, busy);
      end
    end
    set_pattern1();
    capture_exp();
    snap_req = 1'b1;
    @(negedge clk);
    run_frame(-1, 0, 1'b0, 1'b0, -1);
    vectors++;
    if (out_vld !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_frame_end: got vld=%b busy=%b, want 0 0", out_vld, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_drop_counter();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
